// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control unit: FSM states,
// PC/write-back source encodings, ALU codes and instruction field values.
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_BRANCH,
        ST_FAULT
    } state_t;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_ALU    = 2'b01;
    localparam logic [1:0] PC_SRC_MEM    = 2'b10;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b11;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    // TST/TEQ/CMP/CMN occupy ALU codes 1000-1011 and only update flags.
    function automatic logic is_compare(input logic [3:0] fun);
        return fun[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator: pass=1 when cond holds for flags {N,Z,C,V}.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'b0000: pass = w_z;
            4'b0001: pass = !w_z;
            4'b0010: pass = w_c;
            4'b0011: pass = !w_c;
            4'b0100: pass = w_n;
            4'b0101: pass = !w_n;
            4'b0110: pass = w_v;
            4'b0111: pass = !w_v;
            4'b1000: pass = w_c && !w_z;
            4'b1001: pass = !w_c || w_z;
            4'b1010: pass = (w_n == w_v);
            4'b1011: pass = (w_n != w_v);
            4'b1100: pass = !w_z && (w_n == w_v);
            4'b1101: pass = w_z || (w_n != w_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle ARM control FSM: fetch, decode, execute, memory, write-back and
// branch sequencing with a memory-wait watchdog that latches a sticky fault.
module multicycle_control #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15,
    parameter int BUS      = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [31:0]    instr,
    input  logic [3:0]     nzcv,
    input  logic           fetch_ack,
    input  logic           mem_ack,
    output logic           fetch_req,
    output logic           mem_req,
    output logic           mem_we,
    output logic           ir_we,
    output logic           pc_we,
    output logic [1:0]     pc_src,
    output logic           reg_we,
    output logic           cpsr_we,
    output logic [BUS-1:0] wb_addr,
    output logic [1:0]     selwb,
    output logic [3:0]     alu_fun,
    output logic           busy,
    output logic           fault
);

    import arm_ctrl_pkg::*;

    localparam logic [WAIT_W-1:0] CNT_MAX    = '1;
    localparam logic [WAIT_W-1:0] CNT_LAST   = WAIT_W'(MAX_WAIT - 1);
    localparam bit                TIMEOUT_EN = (MAX_WAIT != 0);

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic       w_unused_bits;
    logic       w_cond_pass;
    logic       w_req_pending;
    logic       w_timeout;

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;

    assign w_cond        = instr[31:28];
    assign w_op          = instr[27:26];
    assign w_funct       = instr[25:20];
    assign w_rd          = instr[15:12];
    assign w_unused_bits = ^{w_funct[5], instr[19:16], instr[11:0]};

    cond_check u_cond_check (
        .cond (w_cond),
        .nzcv (nzcv),
        .pass (w_cond_pass)
    );

    assign w_req_pending = (r_state == ST_FETCH && !fetch_ack) ||
                           (r_state == ST_MEM   && !mem_ack);
    // Faulting on the cycle that would bring the count to MAX_WAIT lets an ack
    // arriving in that same cycle still complete the access.
    assign w_timeout = TIMEOUT_EN && w_req_pending && (r_wait_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_FETCH: begin
                if (fetch_ack)      w_state_next = ST_DECODE;
                else if (w_timeout) w_state_next = ST_FAULT;
            end
            ST_DECODE: begin
                if (!w_cond_pass)              w_state_next = ST_FETCH;
                else if (w_op == OP_DP)        w_state_next = ST_EXEC;
                else if (w_op == OP_MEM)       w_state_next = ST_MEM;
                else if (w_op == OP_BRANCH)    w_state_next = ST_BRANCH;
                else                           w_state_next = ST_FAULT;
            end
            ST_MEM: begin
                if (mem_ack)        w_state_next = w_funct[0] ? ST_WB : ST_FETCH;
                else if (w_timeout) w_state_next = ST_FAULT;
            end
            ST_EXEC, ST_WB, ST_BRANCH: w_state_next = ST_FETCH;
            ST_FAULT:                  w_state_next = ST_FAULT;
            default:                   w_state_next = ST_FAULT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state &&
                (w_state_next == ST_FETCH || w_state_next == ST_MEM)) begin
                r_wait_cnt <= '0;
            end else if (w_req_pending && r_wait_cnt != CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred;
    // gating on the reset pin drops requests asynchronously mid-access.
    always_comb begin
        fetch_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        reg_we    = 1'b0;
        cpsr_we   = 1'b0;
        wb_addr   = '0;
        selwb     = WB_SRC_ALU;
        alu_fun   = '0;
        busy      = 1'b0;
        fault     = 1'b0;
        if (reset) begin
            wb_addr = BUS'(w_rd);
            busy    = (r_state != ST_FETCH);
            case (r_state)
                ST_FETCH: begin
                    fetch_req = 1'b1;
                    ir_we     = fetch_ack;
                    pc_we     = fetch_ack;
                end
                ST_EXEC: begin
                    alu_fun = w_funct[4:1];
                    cpsr_we = w_funct[0];
                    if (!is_compare(w_funct[4:1])) begin
                        if (w_rd == REG_PC) begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_ALU;
                        end else begin
                            reg_we = 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    alu_fun = w_funct[3] ? ALU_ADD : ALU_SUB;
                    mem_req = 1'b1;
                    mem_we  = !w_funct[0];
                end
                ST_WB: begin
                    selwb = WB_SRC_MEM;
                    if (w_rd == REG_PC) begin
                        pc_we  = 1'b1;
                        pc_src = PC_SRC_MEM;
                    end else begin
                        reg_we = 1'b1;
                    end
                end
                ST_BRANCH: begin
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_BRANCH;
                    if (w_funct[4]) begin
                        reg_we  = 1'b1;
                        wb_addr = BUS'(REG_LR);
                        selwb   = WB_SRC_LINK;
                    end
                end
                ST_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MAX_WAIT=3; each scenario task
// drives on the falling edge and compares the full output bundle 1ns later.
module tb_multicycle_control;

    typedef struct packed {
        logic       fetch_req;
        logic       mem_req;
        logic       mem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic       cpsr_we;
        logic [3:0] wb_addr;
        logic [1:0] selwb;
        logic [3:0] alu_fun;
        logic       busy;
        logic       fault;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [3:0]  nzcv = 4'h0;
    logic        fetch_ack = 1'b0;
    logic        mem_ack = 1'b0;
    logic        fetch_req, mem_req, mem_we, ir_we, pc_we, reg_we, cpsr_we, busy, fault;
    logic [1:0]  pc_src, selwb;
    logic [3:0]  wb_addr, alu_fun;
    out_t        obs;
    int          n_checks = 0;
    int          n_errors = 0;

    multicycle_control #(.WAIT_W(4), .MAX_WAIT(3), .BUS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .nzcv      (nzcv),
        .fetch_ack (fetch_ack),
        .mem_ack   (mem_ack),
        .fetch_req (fetch_req),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .reg_we    (reg_we),
        .cpsr_we   (cpsr_we),
        .wb_addr   (wb_addr),
        .selwb     (selwb),
        .alu_fun   (alu_fun),
        .busy      (busy),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    assign obs = {fetch_req, mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, cpsr_we,
                  wb_addr, selwb, alu_fun, busy, fault};

    function automatic out_t exp_fetch(input logic [3:0] rd, input logic ack);
        out_t e = '0;
        e.fetch_req = 1'b1;
        e.ir_we     = ack;
        e.pc_we     = ack;
        e.wb_addr   = rd;
        return e;
    endfunction

    function automatic out_t exp_busy(input logic [3:0] rd);
        out_t e = '0;
        e.busy    = 1'b1;
        e.wb_addr = rd;
        return e;
    endfunction

    function automatic out_t exp_mem(input logic [3:0] rd, input logic we, input logic [3:0] fun);
        out_t e = exp_busy(rd);
        e.mem_req = 1'b1;
        e.mem_we  = we;
        e.alu_fun = fun;
        return e;
    endfunction

    task automatic run_fetch(input logic [31:0] ins, input string tag);
        out_t e;
        @(negedge clk);
        instr = ins;
        fetch_ack = 1'b1;
        #1;
        e = exp_fetch(ins[15:12], 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL %s_fetch: got %h expected %h", tag, obs, e);
        end
        @(negedge clk);
        fetch_ack = 1'b0;
        #1;
        e = exp_busy(ins[15:12]);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL %s_decode: got %h expected %h", tag, obs, e);
        end
    endtask

    task automatic apply_reset(input string tag);
        out_t e;
        @(negedge clk);
        reset = 1'b0;
        fetch_ack = 1'b0;
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL %s_held: got %h expected 0", tag, obs);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        e = exp_fetch(instr[15:12], 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL %s_release: got %h expected %h", tag, obs, e);
        end
    endtask

    task automatic test_reset();
        instr = 32'hE081_1002;
        fetch_ack = 1'b1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL reset_ack_ignored: got %h expected 0", obs);
        end
        apply_reset("reset");
    endtask

    // Continues from the first FETCH cycle left by test_reset.
    task automatic test_add();
        out_t e;
        @(negedge clk);
        #1;
        e = exp_fetch(4'd1, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL add_fetch_wait: got %h expected %h", obs, e);
        end
        run_fetch(32'hE081_1002, "add");
        @(negedge clk);
        #1;
        e = exp_busy(4'd1);
        e.reg_we  = 1'b1;
        e.alu_fun = 4'b0100;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL add_exec: got %h expected %h", obs, e);
        end
        @(negedge clk);
        #1;
        e = exp_fetch(4'd1, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL add_back_to_fetch: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_load_pc();
        out_t e;
        run_fetch(32'hE59F_F000, "ldr_pc");
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        e = exp_mem(4'd15, 1'b0, 4'b0100);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL ldr_pc_mem_wait: got %h expected %h", obs, e);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL ldr_pc_mem_ack: got %h expected %h", obs, e);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        e = exp_busy(4'd15);
        e.selwb  = 2'b01;
        e.pc_we  = 1'b1;
        e.pc_src = 2'b10;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL ldr_pc_wb: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_store();
        out_t e;
        run_fetch(32'hE500_2000, "str");
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        e = exp_mem(4'd2, 1'b1, 4'b0010);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL str_mem: got %h expected %h", obs, e);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        e = exp_fetch(4'd2, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL str_to_fetch: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_branch_link();
        out_t e;
        nzcv = 4'b0000;
        run_fetch(32'h0B00_0004, "bleq_z0");
        @(negedge clk);
        nzcv = 4'b0100;
        fetch_ack = 1'b1;
        #1;
        e = exp_fetch(4'd0, 1'b1);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL bleq_skip_to_fetch: got %h expected %h", obs, e);
        end
        @(negedge clk);
        fetch_ack = 1'b0;
        #1;
        @(negedge clk);
        #1;
        e = exp_busy(4'd14);
        e.pc_we  = 1'b1;
        e.pc_src = 2'b11;
        e.reg_we = 1'b1;
        e.selwb  = 2'b10;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL bleq_branch: got %h expected %h", obs, e);
        end
        nzcv = 4'b0000;
    endtask

    task automatic test_exec_variants();
        out_t e;
        run_fetch(32'hE150_0001, "cmp");
        @(negedge clk);
        #1;
        e = exp_busy(4'd0);
        e.alu_fun = 4'b1010;
        e.cpsr_we = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL cmp_exec: got %h expected %h", obs, e);
        end
        run_fetch(32'hE080_F001, "add_pc");
        @(negedge clk);
        #1;
        e = exp_busy(4'd15);
        e.alu_fun = 4'b0100;
        e.pc_we   = 1'b1;
        e.pc_src  = 2'b01;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL add_pc_exec: got %h expected %h", obs, e);
        end
        run_fetch(32'hF081_1002, "never");
        @(negedge clk);
        #1;
        e = exp_fetch(4'd1, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL never_skip: got %h expected %h", obs, e);
        end
        nzcv = 4'b1000;
        run_fetch(32'hB081_1002, "addlt");
        @(negedge clk);
        #1;
        e = exp_busy(4'd1);
        e.alu_fun = 4'b0100;
        e.reg_we  = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL addlt_exec: got %h expected %h", obs, e);
        end
        nzcv = 4'b0000;
    endtask

    task automatic test_timeout();
        out_t e;
        run_fetch(32'hE591_3000, "ldr_to");
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            e = exp_mem(4'd3, 1'b0, 4'b0100);
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL timeout_mem_cycle%0d: got %h expected %h", i, obs, e);
            end
        end
        @(negedge clk);
        fetch_ack = 1'b1;
        mem_ack = 1'b1;
        #1;
        e = exp_busy(4'd3);
        e.fault = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL timeout_fault: got %h expected %h", obs, e);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL timeout_fault_sticky: got %h expected %h", obs, e);
        end
        apply_reset("timeout_reset");
        run_fetch(32'hE591_3000, "ldr_limit");
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            mem_ack = (i == 3);
            #1;
        end
        e = exp_mem(4'd3, 1'b0, 4'b0100);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL limit_ack_mem: got %h expected %h", obs, e);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        e = exp_busy(4'd3);
        e.selwb  = 2'b01;
        e.reg_we = 1'b1;
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL limit_ack_wb: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_reset_mid_mem();
        out_t e;
        run_fetch(32'hE500_2000, "mid_mem");
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        e = exp_mem(4'd2, 1'b1, 4'b0010);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL mid_mem_req: got %h expected %h", obs, e);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL mid_mem_async_clear: got %h expected 0", obs);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_errors++;
            $display("FAIL mid_mem_reset_held: got %h expected 0", obs);
        end
        reset = 1'b1;
        #1;
        e = exp_fetch(4'd2, 1'b0);
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL mid_mem_release: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_undefined_op();
        out_t e;
        run_fetch(32'hEC00_0000, "undef");
        e = exp_busy(4'd0);
        e.fault = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fetch_ack = (i != 0);
            mem_ack = (i != 0);
            #1;
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL undef_fault_cycle%0d: got %h expected %h", i, obs, e);
            end
        end
        apply_reset("undef_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_pc();
        test_store();
        test_branch_link();
        test_exec_variants();
        test_timeout();
        test_reset_mid_mem();
        test_undefined_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_W, default 4: width of the memory-wait timeout counter.
REQ-002 Parameter MAX_WAIT, default 15: number of wait cycles without ack before fault; 0 disables the timeout.
REQ-003 Parameter BUS, default 4: register-address width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 instr  in  32  instruction register contents; fields cond[31:28], op[27:26], funct[25:20], rd[15:12].
REQ-007 nzcv  in  4  current CPSR flags {N,Z,C,V}.
REQ-008 fetch_ack  in  1  instruction memory has returned the word.
REQ-009 mem_ack  in  1  data memory access is complete.
REQ-010 fetch_req  out  1  instruction memory request.
REQ-011 mem_req, mem_we  out  1 each  data memory request; write when mem_we=1.
REQ-012 ir_we, pc_we  out  1 each  instruction-register and PC load strobes.
REQ-013 pc_src  out  2  PC source: 00 PC+4, 01 ALU, 10 memory data, 11 branch target.
REQ-014 reg_we, cpsr_we  out  1 each  register-file and CPSR write strobes.
REQ-015 wb_addr  out  BUS  register-file write address (rd, or 14 for BL).
REQ-016 selwb  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4 (link).
REQ-017 alu_fun  out  4  ALU function code.
REQ-018 busy, fault  out  1 each  busy=1 in any state except FETCH; fault=1 is sticky.

Function
REQ-019 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, BRANCH and FAULT.
REQ-020 FETCH: fetch_req=1 until fetch_ack; in the ack cycle ir_we=1, pc_we=1 and pc_src=00; next state DECODE.
REQ-021 DECODE: a cond check against nzcv SHALL cover all 15 ARM codes plus 1111 (never).
- Failed check -> FETCH with no strobes.
- op=00 -> EXEC; op=01 -> MEM; op=10 -> BRANCH; op=11 -> FAULT.
REQ-022 EXEC (1 cycle, then FETCH): alu_fun=funct[4:1] and cpsr_we=funct[0].
- Compare ops (alu_fun 1000-1011): reg_we=0.
- Otherwise, rd=1111: pc_we=1, pc_src=01, reg_we=0; any other rd: reg_we=1, selwb=00.
REQ-023 MEM: alu_fun=0100 if funct[3]=1 (U), else 0010; mem_req=1 and mem_we=~funct[0] held until mem_ack.
- On ack: load -> WB; store -> FETCH.
REQ-024 WB (1 cycle, then FETCH): selwb=01.
- rd=1111: pc_we=1, pc_src=10, reg_we=0.
- Any other rd: reg_we=1.
REQ-025 BRANCH (1 cycle, then FETCH): pc_we=1, pc_src=11.
- If funct[4]=1 (BL): reg_we=1, wb_addr=14, selwb=10.
REQ-026 wb_addr SHALL equal rd in every state except BL.
REQ-027 Strobes (ir_we, pc_we, reg_we, cpsr_we) SHALL be single-cycle and SHALL be 0 in all cases not listed above.
REQ-028 Timeout counter: clears on entry to FETCH or MEM; increments each cycle the request is high without ack; saturates at its maximum.
- Counter reaching MAX_WAIT (with MAX_WAIT != 0) -> FAULT.
- An ack in the same cycle as the limit wins: no fault.
REQ-029 FAULT: every request and strobe is 0, fault=1; the FSM leaves FAULT only on reset.
REQ-030 Output timing: FSM outputs are Moore except the ack-qualified strobes, which are Mealy on fetch_ack/mem_ack.

Reset
REQ-031 While reset=0: state=FETCH, counter=0, fault=0 and every output 0.
- After reset=1, fetch_req rises in the first cycle.
REQ-032 Reset mid-access abandons the request at once, with no strobe issued.

Structure
REQ-033 The state enum, pc_src/selwb encodings and ALU codes (ADD 0100, SUB 0010) SHALL live in a shared package, arm_ctrl_pkg.
REQ-034 The condition check SHALL be a combinational sub-module, cond_check (cond, nzcv -> pass).

Verification
REQ-035 ADD r1 (E0811002) with fetch_ack after 2 cycles, then:
- FETCH held 3 cycles, then DECODE, then EXEC with reg_we=1, wb_addr=1, alu_fun=0100.
REQ-036 LDR r15 (E59FF000), mem_ack after 1 cycle:
- WB gives pc_we=1, pc_src=10, reg_we=0.
REQ-037 BLEQ (0B000004): Z=0 -> FETCH with no strobes; Z=1 -> BRANCH with pc_src=11, reg_we=1, wb_addr=14, selwb=10.
REQ-038 MAX_WAIT=3 and mem_ack never asserted:
- fault=1 on the 4th MEM cycle; then all strobes 0.
- mem_ack exactly at the limit: no fault.
REQ-039 reset=0 pulsed during MEM with mem_req=1:
- all outputs 0 asynchronously; FETCH after release.
REQ-040 op=11 instruction -> FAULT; fault stays high under later fetch_ack/mem_ack until reset.
